// File: rtl/isqrt_norm.sv
// Iterative restoring square root: floor(sqrt(i_data)) and remainder, one root bit per cycle.
// Single calculation in flight; valid/ready handshakes on both sides.
module isqrt_norm #(
  parameter  int IN_WIDTH    = 10,
  parameter  int INSTANCE_ID = 0,
  localparam int OUT_WIDTH   = (IN_WIDTH + 1) / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [IN_WIDTH-1:0]  i_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [OUT_WIDTH-1:0] o_root,
  output logic [OUT_WIDTH:0]   o_rem
);

  localparam int RW  = 2 * OUT_WIDTH;
  localparam int MW  = OUT_WIDTH + 2;
  localparam int FW  = OUT_WIDTH + 4;
  localparam int CW  = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int OW1 = OUT_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [RW-1:0]          r_rad;
  logic [MW-1:0]          r_rem;
  logic [OUT_WIDTH-1:0]   r_root;
  logic [CW-1:0]          r_cnt;

  logic [FW-1:0]          w_trial;
  logic [FW-1:0]          w_test;
  logic                   w_ge;
  logic [FW-1:0]          w_rem_full;
  logic [OUT_WIDTH-1:0]   w_root_nxt;
  logic                   w_last;

  // Compare at full width so the shifted remainder never loses bits before truncation.
  assign w_trial    = {r_rem, r_rad[RW-1 -: 2]};
  assign w_test     = {4'b0000, r_root, 2'b01} ;
  assign w_ge       = (w_trial >= w_test);
  assign w_rem_full = w_ge ? (w_trial - w_test) : w_trial;
  assign w_root_nxt = OUT_WIDTH'({r_root, w_ge});
  assign w_last     = (r_cnt == {CW{1'b0}});

  assign i_ready = (r_state == S_IDLE);
  assign o_valid = (r_state == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_state_nxt = S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE: begin
        if (o_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: capture radicand, iterate one root bit per cycle, publish result on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rad  <= {RW{1'b0}};
      r_rem  <= {MW{1'b0}};
      r_root <= {OUT_WIDTH{1'b0}};
      r_cnt  <= {CW{1'b0}};
      o_root <= {OUT_WIDTH{1'b0}};
      o_rem  <= {OW1{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_rad  <= RW'(i_data);
            r_rem  <= {MW{1'b0}};
            r_root <= {OUT_WIDTH{1'b0}};
            r_cnt  <= CW'(OUT_WIDTH - 1);
          end
        end
        S_CALC: begin
          r_rad  <= r_rad << 2;
          r_rem  <= MW'(w_rem_full);
          r_root <= w_root_nxt;
          r_cnt  <= r_cnt - CW'(1);
          if (w_last) begin
            o_root <= w_root_nxt;
            o_rem  <= OW1'(w_rem_full);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_norm.sv
// Directed bench for isqrt_norm: reset, boundary values, full sweep, back-pressure,
// back-to-back throughput and mid-calculation reset.
module tb_isqrt_norm;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       i_ready;
  logic [9:0] i_data;
  logic       o_valid;
  logic       o_ready;
  logic [4:0] o_root;
  logic [5:0] o_rem;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  isqrt_norm #(.IN_WIDTH(10), .INSTANCE_ID(0)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_root  (o_root),
    .o_rem   (o_rem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Present a radicand and wait for the accepting edge; returns at #1 after it.
  task automatic send(input logic [9:0] x, input bit keep, output bit ok, output int acc);
    ok = 1'b0;
    acc = 0;
    i_data = x;
    i_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (i_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (!keep) i_valid = 1'b0;
  endtask

  // Wait for o_valid, counting edges since the call.
  task automatic wait_out(output bit ok, output int lat);
    ok = 1'b0;
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      lat++;
      if (o_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b1; i_data = 10'd5; o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; i_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready: got %0d expected 1", i_ready); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %0d expected 0", o_valid); end
    n_checks++; if (o_root !== 5'd0) begin n_fail++; $display("FAIL reset_o_root: got %0d expected 0", o_root); end
    n_checks++; if (o_rem !== 6'd0) begin n_fail++; $display("FAIL reset_o_rem: got %0d expected 0", o_rem); end
  endtask

  task automatic test_zero;
    bit ok; int acc; int lat;
    o_ready = 1'b1;
    send(10'd0, 1'b0, ok, acc);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_accept: got timeout expected accept"); end
    wait_out(ok, lat);
    n_checks++; if (!ok || lat != 5) begin n_fail++; $display("FAIL zero_latency: got %0d (ok=%0d) expected 5", lat, ok); end
    n_checks++; if (o_root !== 5'd0) begin n_fail++; $display("FAIL zero_root: got %0d expected 0", o_root); end
    n_checks++; if (o_rem !== 6'd0) begin n_fail++; $display("FAIL zero_rem: got %0d expected 0", o_rem); end
    @(posedge clk); #1;
    n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready_after_hs: got %0d expected 1", i_ready); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid_after_hs: got %0d expected 0", o_valid); end
  endtask

  task automatic test_boundaries;
    logic [9:0] xs [3];
    int er [3];
    int em [3];
    bit ok; int acc; int lat;
    xs[0] = 10'd900;  er[0] = 30; em[0] = 0;
    xs[1] = 10'd1023; er[1] = 31; em[1] = 62;
    xs[2] = 10'd72;   er[2] = 8;  em[2] = 8;
    o_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(xs[k], 1'b0, ok, acc);
      wait_out(ok, lat);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bound_valid x=%0d: got timeout expected o_valid", xs[k]); end
      n_checks++; if (o_root !== 5'(er[k])) begin n_fail++; $display("FAIL bound_root x=%0d: got %0d expected %0d", xs[k], o_root, er[k]); end
      n_checks++; if (o_rem !== 6'(em[k])) begin n_fail++; $display("FAIL bound_rem x=%0d: got %0d expected %0d", xs[k], o_rem, em[k]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sweep;
    bit ok; int acc; int lat; int x; int r;
    o_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      x = (i * 37 + 11) % 1024;
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      send(10'(x), 1'b0, ok, acc);
      wait_out(ok, lat);
      n_checks++;
      if (!ok || o_root !== 5'(r) || o_rem !== 6'(x - r * r)) begin
        n_fail++; $display("FAIL sweep x=%0d: got root %0d rem %0d expected root %0d rem %0d", x, o_root, o_rem, r, x - r * r);
      end
      n_checks++;
      if (int'(o_root) * int'(o_root) + int'(o_rem) != x || int'(o_rem) > 2 * int'(o_root)) begin
        n_fail++; $display("FAIL sweep_invariant x=%0d: got root %0d rem %0d", x, o_root, o_rem);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    bit ok; int acc; int lat; bit stable;
    o_ready = 1'b0;
    send(10'd50, 1'b0, ok, acc);
    wait_out(ok, lat);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_valid: got timeout expected o_valid"); end
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (o_valid !== 1'b1 || o_root !== 5'd7 || o_rem !== 6'd1 || i_ready !== 1'b0) begin
        stable = 1'b0;
        $display("FAIL bp_hold cycle %0d: got valid %0d root %0d rem %0d i_ready %0d expected 1 7 1 0", k, o_valid, o_root, o_rem, i_ready);
      end
      i_valid = 1'b1; i_data = 10'd16;
      @(posedge clk); #1;
    end
    n_checks++; if (!stable) n_fail++;
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_still_valid: got %0d expected 1", o_valid); end
    o_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %0d expected 0", o_valid); end
    n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise: got %0d expected 1", i_ready); end
    @(posedge clk); #1;
    i_valid = 1'b0;
    n_checks++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL bp_new_accept: got i_ready %0d expected 0", i_ready); end
    wait_out(ok, lat);
    n_checks++; if (!ok || lat != 5) begin n_fail++; $display("FAIL bp_next_latency: got %0d (ok=%0d) expected 5", lat, ok); end
    n_checks++; if (o_root !== 5'd4 || o_rem !== 6'd0) begin n_fail++; $display("FAIL bp_next_result: got root %0d rem %0d expected 4 0", o_root, o_rem); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [9:0] xs [4];
    int er [4];
    int em [4];
    int accs [4];
    bit ok; int lat; bit quiet;
    xs[0] = 10'd100; er[0] = 10; em[0] = 0;
    xs[1] = 10'd101; er[1] = 10; em[1] = 1;
    xs[2] = 10'd255; er[2] = 15; em[2] = 30;
    xs[3] = 10'd256; er[3] = 16; em[3] = 0;
    o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(xs[k], (k < 3), ok, accs[k]);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_accept %0d: got timeout expected accept", k); end
      if (k > 0) begin
        n_checks++;
        if (accs[k] - accs[k-1] != 7) begin n_fail++; $display("FAIL b2b_interval %0d: got %0d expected 7", k, accs[k] - accs[k-1]); end
      end
      wait_out(ok, lat);
      n_checks++;
      if (!ok || o_root !== 5'(er[k]) || o_rem !== 6'(em[k])) begin
        n_fail++; $display("FAIL b2b_result %0d: got root %0d rem %0d expected %0d %0d", k, o_root, o_rem, er[k], em[k]);
      end
    end
    i_valid = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b0) quiet = 1'b0;
    end
    n_checks++; if (!quiet) begin n_fail++; $display("FAIL b2b_no_duplicate: got extra o_valid expected none"); end
  endtask

  task automatic test_reset_mid;
    bit ok; int acc; int lat; bit quiet;
    o_ready = 1'b1;
    send(10'd500, 1'b0, ok, acc);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_accept: got timeout expected accept"); end
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0d expected 0", o_valid); end
    n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %0d expected 1", i_ready); end
    n_checks++; if (o_root !== 5'd0) begin n_fail++; $display("FAIL rmid_root_cleared: got %0d expected 0", o_root); end
    quiet = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b0) quiet = 1'b0;
    end
    n_checks++; if (!quiet) begin n_fail++; $display("FAIL rmid_no_output: got o_valid expected none"); end
    send(10'd16, 1'b0, ok, acc);
    wait_out(ok, lat);
    n_checks++; if (!ok || lat != 5) begin n_fail++; $display("FAIL rmid_next_latency: got %0d (ok=%0d) expected 5", lat, ok); end
    n_checks++; if (o_root !== 5'd4 || o_rem !== 6'd0) begin n_fail++; $display("FAIL rmid_next_result: got root %0d rem %0d expected 4 0", o_root, o_rem); end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_data = 10'd0; o_ready = 1'b0;
    test_reset;
    test_zero;
    test_boundaries;
    test_sweep;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/isqrt_norm.md
Name: isqrt_norm

Overview:
- Iterative unsigned integer square-root unit that consumes the sum-of-squares result from the multiplier/adder-tree datapath and recovers the L2 norm: floor(sqrt(x)) plus the remainder.
- Sits downstream of the sum-of-squares pipeline.
- Input and output use valid/ready handshakes so that producer stall and consumer back-pressure both work.
- One result bit per cycle, restoring digit-by-digit algorithm. There is one calculation in flight at a time.

Parameters:
- IN_WIDTH, 10, radicand width. Default matches the sum-of-squares output width for 4-bit operands.
- OUT_WIDTH, (IN_WIDTH+1)/2 (integer division), root width. Derived; must not be overridden.
- INSTANCE_ID, 0, instance tag. No functional effect.

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- i_valid  input  1  radicand valid
- i_ready  output  1  unit can accept a radicand
- i_data  input  IN_WIDTH  unsigned radicand
- o_valid  output  1  result valid
- o_ready  input  1  consumer accepts result
- o_root  output  OUT_WIDTH  floor(sqrt(i_data))
- o_rem  output  OUT_WIDTH+1  i_data - o_root^2

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state is registered.
- Reset values:
  - state = IDLE
  - o_valid = 0
  - o_root = 0
  - o_rem = 0
  - internal radicand, partial remainder and iteration counter = 0
  - i_ready = 1 from the first cycle after reset deasserts
  - While rst is high, i_valid and o_ready are ignored.
- FSM states: IDLE, CALC, DONE. i_ready = (state == IDLE). o_valid = (state == DONE).
- IDLE:
  - When i_valid && i_ready at an edge: capture i_data, zero-extended to 2*OUT_WIDTH bits.
  - Clear partial root and remainder; set counter = OUT_WIDTH - 1; go to CALC.
- CALC, one iteration per edge:
  - r' = (rem << 2) | next two radicand bits, MSB pair first.
  - t = (root << 2) | 1.
  - If r' >= t: rem = r' - t, root = (root << 1) | 1. Otherwise: rem = r', root = root << 1.
  - Internal remainder is OUT_WIDTH+2 bits, so no overflow is possible.
  - After OUT_WIDTH iterations (counter reaches 0 on the final one): write o_root and o_rem, go to DONE.
- Latency: accept at edge E0; o_valid is high in the cycle following edge E0+OUT_WIDTH (5 cycles at default).
- DONE:
  - o_valid is held high, and o_root/o_rem are held stable, until o_valid && o_ready at an edge.
  - At that edge go to IDLE.
  - i_ready stays 0 throughout DONE. A new radicand is therefore accepted no earlier than the edge after the output handshake.
  - Minimum initiation interval is OUT_WIDTH + 2 cycles.
- After the output handshake, o_root/o_rem keep their last values; they are don't-care while o_valid = 0. They are updated only on entry to DONE.
- i_valid is ignored in CALC and DONE. A producer must hold i_data stable until it sees i_ready.
- o_ready is ignored outside DONE. o_ready held high in advance gives a single-cycle DONE.
- Boundary conditions:
  - i_data = 0 gives root 0, rem 0.
  - All-ones input gives maximum root and rem = 2*root.
  - Odd IN_WIDTH: the top pad bit is 0.
  - Invariant on every result: root^2 + rem == i_data and rem <= 2*root.
- Reset mid-CALC or mid-DONE:
  - Abort with no output. o_valid drops in the cycle after the reset edge.
  - The in-flight radicand is discarded, not replayed.

Test Plan:
- Reset, then i_data = 0 with o_ready = 1 -> o_valid high 5 cycles after accept; o_root = 0, o_rem = 0; i_ready returns to 1 the cycle after the handshake.
- i_data = 900 (4*15^2, max sum of squares), then 1023 -> root 30 rem 0, then root 31 rem 62; results in order.
- Operands 2, 4, 4, 6 give i_data = 72 -> root 8, rem 8. Random sweep of all 1024 values -> invariant root^2 + rem == x and rem <= 2*root on every result.
- o_ready held low 10 cycles after o_valid with i_data = 50 -> o_valid, o_root = 7 and o_rem = 1 all stable; i_ready = 0; a new i_valid is not accepted until one cycle after o_ready rises.
- Back-to-back: i_valid held high over 4 radicands, o_ready = 1 -> one acceptance every 7 cycles; no input dropped or duplicated.
- rst pulsed 1 cycle at the third CALC iteration of i_data = 500 -> no o_valid for that input; i_ready = 1 next cycle; the following i_data = 16 yields root 4, rem 0.
